// File: rtl/cavlc_coeff_rebuilder.sv
// Rebuilds a 4x4 coefficient block in scan order from CAVLC syntax values and writes it to the coefficient BRAM.
// First write the cycle after acceptance; level/run streams stall the write pipe via valid/ready.
module cavlc_coeff_rebuilder #(
  parameter int WORD_W = 9,
  parameter int N_COEF = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              start_ready,
  input  logic [4:0]        total_coeff,
  input  logic [1:0]        trail_ones,
  input  logic [2:0]        trail_sign,
  input  logic [3:0]        total_zeros,
  input  logic              level_valid,
  output logic              level_ready,
  input  logic [WORD_W-1:0] level_word,
  input  logic              run_valid,
  output logic              run_ready,
  input  logic [3:0]        run_before,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HIGHZ  = 3'd1;
  localparam logic [2:0] COEF   = 3'd2;
  localparam logic [2:0] RUNREQ = 3'd3;
  localparam logic [2:0] ZRUN   = 3'd4;
  localparam logic [2:0] TAILZ  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0] state;
  logic [4:0] tcReg;
  logic [1:0] t1Reg;
  logic [2:0] signReg;
  logic [4:0] limit;
  logic [3:0] zerosLeft;
  logic [3:0] addr;
  logic [4:0] coefIdx;
  logic [3:0] runCnt;

  logic [5:0] descSum;
  logic [4:0] descLimit;
  logic       descBad;
  logic       isT1;
  logic [1:0] t1Sel;
  logic       coefWr;
  logic       lastCoef;
  logic       runOver;
  logic [3:0] runClamp;

  assign descSum   = {1'b0, total_coeff} + {2'b0, total_zeros};
  assign descBad   = (total_coeff > 5'(N_COEF)) || ({3'b0, trail_ones} > total_coeff)
                     || (descSum > 6'(N_COEF));
  // An empty block zero-fills every address, so its high-zero region reaches down to 0.
  assign descLimit = (total_coeff == 5'd0) ? 5'd0 : descSum[4:0];

  assign isT1     = coefIdx < {3'b0, t1Reg};
  assign t1Sel    = t1Reg - coefIdx[1:0] - 2'd1;
  assign coefWr   = (state == COEF) && (isT1 || level_valid);
  assign lastCoef = coefIdx == (tcReg - 5'd1);
  assign runOver  = run_before > zerosLeft;
  assign runClamp = runOver ? zerosLeft : run_before;

  assign start_ready = state == IDLE;
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = state == DONE;
  assign level_ready = (state == COEF) && !isT1;
  assign run_ready   = state == RUNREQ;
  assign wr_en       = (state == HIGHZ) || coefWr || (state == ZRUN) || (state == TAILZ);
  assign wr_addr     = addr;

  always_comb begin
    wr_data = '0;
    if (coefWr) begin
      if (isT1) wr_data = {signReg[t1Sel], (WORD_W-1)'(1)};
      else      wr_data = level_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tcReg     <= '0;
      t1Reg     <= '0;
      signReg   <= '0;
      limit     <= '0;
      zerosLeft <= '0;
      addr      <= '0;
      coefIdx   <= '0;
      runCnt    <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (descBad) begin
              err <= 1'b1;
            end else begin
              tcReg     <= total_coeff;
              t1Reg     <= trail_ones;
              signReg   <= trail_sign;
              limit     <= descLimit;
              zerosLeft <= total_zeros;
              addr      <= 4'(N_COEF - 1);
              coefIdx   <= '0;
              state     <= descLimit[4] ? COEF : HIGHZ;
            end
          end
        end
        HIGHZ: begin
          addr <= addr - 4'd1;
          if ({1'b0, addr} == limit) state <= (tcReg == 5'd0) ? DONE : COEF;
        end
        COEF: begin
          if (coefWr) begin
            addr    <= addr - 4'd1;
            coefIdx <= coefIdx + 5'd1;
            if (lastCoef)              state <= (addr == 4'd0) ? DONE : TAILZ;
            else if (zerosLeft != 4'd0) state <= RUNREQ;
          end
        end
        RUNREQ: begin
          if (run_valid) begin
            // An oversized run is flagged but clamped so the block still fills exactly.
            err       <= runOver;
            zerosLeft <= zerosLeft - runClamp;
            runCnt    <= runClamp;
            state     <= (runClamp != 4'd0) ? ZRUN : COEF;
          end
        end
        ZRUN: begin
          addr   <= addr - 4'd1;
          runCnt <= runCnt - 4'd1;
          if (runCnt == 4'd1) state <= COEF;
        end
        TAILZ: begin
          addr <= addr - 4'd1;
          if (addr == 4'd0) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_coeff_rebuilder.sv
// Scoreboard bench for cavlc_coeff_rebuilder: directed blocks push expected writes, a negedge monitor pops and compares.
module tb_cavlc_coeff_rebuilder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       start_ready;
  logic [4:0] total_coeff = '0;
  logic [1:0] trail_ones = '0;
  logic [2:0] trail_sign = '0;
  logic [3:0] total_zeros = '0;
  logic       level_valid = 1'b0;
  logic       level_ready;
  logic [8:0] level_word = '0;
  logic       run_valid = 1'b0;
  logic       run_ready;
  logic [3:0] run_before = '0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy, done, err;

  cavlc_coeff_rebuilder #(.WORD_W(9), .N_COEF(16)) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .total_coeff(total_coeff), .trail_ones(trail_ones), .trail_sign(trail_sign),
    .total_zeros(total_zeros), .level_valid(level_valid), .level_ready(level_ready),
    .level_word(level_word), .run_valid(run_valid), .run_ready(run_ready),
    .run_before(run_before), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [12:0] expQ[$];
  logic [8:0]  levelQ[$];
  logic [3:0]  runQ[$];
  int cyc = 0, lvlHs = 0, runHs = 0, errCnt = 0, errCyc = 0, doneCnt = 0, doneCyc = 0;
  int wrCount = 0, lastWr0 = 0, readyCyc = 0;
  logic stall = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Input driver: pops consumed words after each edge and presents the next one.
  initial forever begin
    logic lh, rh;
    @(posedge clk);
    cyc++;
    lh = level_valid && level_ready;
    rh = run_valid && run_ready;
    #1;
    if (lh) begin void'(levelQ.pop_front()); lvlHs++; end
    if (rh) begin void'(runQ.pop_front()); runHs++; end
    level_valid = (levelQ.size() != 0) && !stall;
    level_word  = (levelQ.size() != 0) ? levelQ[0] : 9'd0;
    run_valid   = runQ.size() != 0;
    run_before  = (runQ.size() != 0) ? runQ[0] : 4'd0;
  end

  // Monitor: scoreboard for writes plus protocol checks.
  initial forever begin
    logic [12:0] e;
    @(negedge clk);
    if (!rst) begin
      wrCount = 0;
    end else begin
      if (wr_en) begin
        if (expQ.size() == 0) begin
          chk("unexpected_write_addr", int'(wr_addr), -1);
        end else begin
          e = expQ.pop_front();
          chk("wr_addr", int'(wr_addr), int'(e[12:9]));
          chk("wr_data", int'(wr_data), int'(e[8:0]));
        end
        wrCount++;
        if (wr_addr == 4'd0) lastWr0 = cyc;
      end else begin
        chk("wr_data_idle_zero", int'(wr_data), 0);
      end
      chk("ready_exclusive", int'(level_ready && run_ready), 0);
      if (level_ready || run_ready) readyCyc++;
      if (err) begin errCnt++; errCyc = cyc; end
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
        chk("done_after_addr0", cyc, lastWr0 + 1);
        chk("writes_per_block", wrCount, 16);
        chk("busy_low_at_done", int'(busy), 0);
        wrCount = 0;
      end
    end
  end

  task automatic push(input int a, input int d);
    expQ.push_back({4'(a), 9'(d)});
  endtask

  task automatic pushZeros(input int hi, input int lo);
    for (int a = hi; a >= lo; a--) push(a, 0);
  endtask

  task automatic startBlock(input int tc, input int t1, input int sg, input int tz, output int acc);
    int n = 0;
    @(negedge clk);
    while (!start_ready && n < 200) begin @(negedge clk); n++; end
    if (!start_ready) chk("start_ready_timeout", 0, 1);
    start = 1'b1;
    total_coeff = 5'(tc); trail_ones = 2'(t1); trail_sign = 3'(sg); total_zeros = 4'(tz);
    @(posedge clk);
    #1 acc = cyc;
    start = 1'b0;
  endtask

  task automatic waitDone(input int prev);
    int n = 0;
    while (doneCnt == prev && n < 300) begin @(negedge clk); #1; n++; end
    if (doneCnt == prev) chk("done_timeout", doneCnt, prev + 1);
  endtask

  task automatic illegal(input int tc, input int t1, input int tz);
    int acc, e0, d0;
    e0 = errCnt; d0 = doneCnt;
    startBlock(tc, t1, 0, tz, acc);
    repeat (3) @(negedge clk);
    chk("illegal_err_count", errCnt - e0, 1);
    chk("illegal_err_cycle", errCyc, acc);
    chk("illegal_no_done", doneCnt - d0, 0);
    chk("illegal_no_write", wrCount, 0);
    chk("illegal_start_ready", int'(start_ready), 1);
  endtask

  task automatic mixedBlock();
    int acc, d0, l0, r0;
    pushZeros(15, 5);
    push(4, 'h001); push(3, 'h101); push(2, 'h003); push(1, 'h000); push(0, 'h005);
    levelQ.push_back(9'h003); levelQ.push_back(9'h005);
    runQ.push_back(4'd0); runQ.push_back(4'd0); runQ.push_back(4'd1);
    d0 = doneCnt; l0 = lvlHs; r0 = runHs;
    startBlock(4, 2, 3'b001, 1, acc);
    waitDone(d0);
    chk("mixed_done_cycle", doneCyc, acc + 19);
    chk("mixed_level_hs", lvlHs - l0, 2);
    chk("mixed_run_hs", runHs - r0, 3);
  endtask

  initial begin
    int acc, d0, l0, r0, rc0, e0, n;
    #2;
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_readies", int'(level_ready || run_ready), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    mixedBlock();

    // Empty block, with a start attempt while busy that must be ignored.
    pushZeros(15, 0);
    d0 = doneCnt; rc0 = readyCyc;
    startBlock(0, 0, 0, 0, acc);
    repeat (2) @(negedge clk);
    start = 1'b1; total_coeff = 5'd16; total_zeros = 4'd0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    waitDone(d0);
    chk("empty_done_cycle", doneCyc, acc + 16);
    chk("empty_no_ready", readyCyc - rc0, 0);
    chk("empty_busy_start_ignored", doneCnt - d0, 1);

    // Full block of 16 levels, no runs, no bubbles.
    for (int i = 0; i < 16; i++) begin
      levelQ.push_back(9'(i * 17 + 3) ^ ((i % 3 == 0) ? 9'h100 : 9'h000));
      push(15 - i, int'(9'(i * 17 + 3) ^ ((i % 3 == 0) ? 9'h100 : 9'h000)));
    end
    d0 = doneCnt; l0 = lvlHs; r0 = runHs;
    startBlock(16, 0, 0, 0, acc);
    waitDone(d0);
    chk("full_done_cycle", doneCyc, acc + 16);
    chk("full_level_hs", lvlHs - l0, 16);
    chk("full_run_hs", runHs - r0, 0);

    // Level stall for 5 cycles, then a run_before that overflows zeros_left.
    pushZeros(15, 4); push(3, 'h00A); push(2, 0); push(1, 0); push(0, 'h187);
    levelQ.push_back(9'h00A); levelQ.push_back(9'h187);
    runQ.push_back(4'd3);
    stall = 1'b1;
    d0 = doneCnt; e0 = errCnt;
    startBlock(2, 0, 0, 2, acc);
    n = 0;
    while (!level_ready && n < 100) begin @(negedge clk); n++; end
    chk("stall_level_ready_seen", int'(level_ready), 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_wr_en", int'(wr_en), 0);
      chk("stall_addr_held", int'(wr_addr), 3);
    end
    stall = 1'b0;
    waitDone(d0);
    chk("stall_done_cycle", doneCyc, acc + 22);
    chk("overflow_err_count", errCnt - e0, 1);

    illegal(2, 3, 0);
    illegal(10, 0, 8);
    illegal(17, 0, 0);

    // Reset at the 7th write of an empty block.
    pushZeros(15, 0);
    d0 = doneCnt;
    startBlock(0, 0, 0, 0, acc);
    n = 0;
    while (wrCount != 7 && n < 50) begin @(negedge clk); #1; n++; end
    chk("reset_reached_7_writes", wrCount, 7);
    rst = 1'b0;
    #1;
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_start_ready", int'(start_ready), 1);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("midrst_no_done", doneCnt - d0, 0);

    mixedBlock();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", expQ.size(), 0);
    chk("levels_drained", levelQ.size(), 0);
    chk("runs_drained", runQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
